conv_mem_host: RTL and testbench
================================

CONV_MEM_HOST -- requirements
Module: conv_mem_host

Interface
REQ-001 The block SHALL use clock clk and reset reset, where reset is asynchronous and active-high.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port ld_valid, input, 1 bit: an image-load word is present.
REQ-005 Port ld_ready, output, 1 bit: the block accepts image-load words.
REQ-006 Port ld_data, input, 13 bits: image pixel, signed Q9.4.
REQ-007 Port ready, output, 1 bit: image is loaded; convolution engine may start.
REQ-008 Port busy, input, 1 bit: convolution engine is running.
REQ-009 Port iaddr, input, 12 bits: image read address {row[5:0], col[5:0]}.
REQ-010 Port idata, output, 13 bits: signed image pixel at iaddr.
REQ-011 Port cwr, input, 1 bit: layer-memory write strobe.
REQ-012 Port caddr_wr, input, 12 bits: layer-memory write address.
REQ-013 Port cdata_wr, input, 13 bits: layer-memory write data.
REQ-014 Port crd, input, 1 bit: layer-memory read enable.
REQ-015 Port caddr_rd, input, 12 bits: layer-memory read address.
REQ-016 Port cdata_rd, output, 13 bits: layer-memory read data.
REQ-017 Port csel, input, 1 bit: bank select; 0 = layer0 (4096 words), 1 = layer1 (1024 words).
REQ-018 Port dout_valid, output, 1 bit: result word present.
REQ-019 Port dout_ready, input, 1 bit: downstream accepts the result word.
REQ-020 Port dout_data, output, 13 bits: layer1 result word.
REQ-021 Port dout_last, output, 1 bit: current result word is layer1 address 1023.
REQ-022 Port done, output, 1 bit: one-cycle pulse when the dump completes.
REQ-023 Port err, output, 1 bit: sticky error flag for illegal layer1 access.

Function
REQ-024 Storage SHALL be: image memory of 4096 x 13 bits, layer0 of 4096 x 13 bits, and layer1 of 1024 x 13 bits.
REQ-025 The FSM SHALL have states LOAD, START, RUN, DUMP and DONE.
REQ-026 LOAD: ld_ready = 1 (decoded combinationally from state); each ld_valid & ld_ready cycle writes ld_data to img[ld_cnt] and increments the 12-bit ld_cnt; acceptance of word 4095 moves the FSM to START and clears ld_cnt.
REQ-027 START: ready SHALL be registered 1 from the first START cycle and held until busy is sampled 1; that edge moves the FSM to RUN and clears ready.
REQ-028 RUN: when busy is sampled 0, the FSM SHALL move to DUMP.
REQ-029 idata SHALL equal img[iaddr] combinationally (zero-latency read) in every state, because the engine samples it on the edge after driving iaddr.
REQ-030 cdata_rd SHALL equal, combinationally: layer0[caddr_rd] when crd = 1 and csel = 0; layer1[caddr_rd[9:0]] when crd = 1, csel = 1 and caddr_rd[11:10] = 0; otherwise 0.
REQ-031 A write SHALL occur on the rising edge only in RUN with cwr = 1, storing cdata_wr to layer0[caddr_wr] when csel = 0, or to layer1[caddr_wr[9:0]] when csel = 1.
REQ-032 cwr outside RUN SHALL be ignored, with no error.
REQ-033 A csel = 1 write with caddr_wr > 1023 SHALL be dropped and set err.
REQ-034 A csel = 1 read with crd = 1 and caddr_rd > 1023 SHALL return 0 and set err.
REQ-035 A simultaneous read and write to the same bank and address SHALL return the pre-write value; the new value is visible from the next cycle.
REQ-036 DUMP: dout_valid SHALL be 1 and dout_data SHALL be layer1[d_cnt], with the 10-bit d_cnt starting at 0.
REQ-037 In DUMP, d_cnt SHALL advance on dout_valid & dout_ready; dout_data and dout_last SHALL hold stable while dout_ready = 0; dout_last SHALL be 1 when d_cnt = 1023.
REQ-038 Acceptance of the last word in DUMP SHALL move the FSM to DONE and clear d_cnt.
REQ-039 DONE SHALL last exactly one cycle with done = 1, then move to LOAD; err SHALL remain held.
REQ-040 dout_data SHALL be 0 whenever dout_valid = 0.
REQ-041 ld_valid outside LOAD SHALL be ignored, with no write.
REQ-042 busy = 1 seen in LOAD SHALL be ignored.
REQ-043 If busy never rises, the FSM SHALL remain in START.

Reset
REQ-044 On reset assertion, the block SHALL immediately go to LOAD with ld_cnt = 0, d_cnt = 0, ld_ready = 1, ready = 0, dout_valid = 0, dout_last = 0, dout_data = 0, done = 0 and err = 0.
REQ-045 Memory contents SHALL NOT be cleared by reset.
REQ-046 Reset mid-LOAD, mid-RUN or mid-DUMP SHALL abandon the operation; the next load restarts at img[0].

Verification
REQ-047 The bench SHALL cover: load 4096 words with value = address[11:0] mod 8192, ld_valid randomly gapped -> exactly 4096 accepted; ready = 1 on the cycle after the final acceptance; img readback via iaddr = 0x041 gives idata = 0x041.
REQ-048 The bench SHALL cover: in RUN, cwr = 1, csel = 0, caddr_wr = 0x7FF, cdata_wr = 0x0123, while crd = 1, caddr_rd = 0x7FF -> cdata_rd = old value in that cycle and 0x0123 in the next cycle.
REQ-049 The bench SHALL cover: csel = 1 write to 0x400 with data 0x0055 -> err = 1, layer1[0] unchanged; csel = 1 read of 0x800 -> cdata_rd = 0.
REQ-050 The bench SHALL cover: fill layer1[i] = i, drop busy, dout_ready toggling 1/0 -> 1024 words 0..1023 in order, dout_last only on 1023, data stable during stalls, done pulses for one cycle, then ld_ready = 1.
REQ-051 The bench SHALL cover: ready held while busy stays 0 for 50 cycles -> remains in START with ready = 1; busy = 1 -> ready = 0 on the next cycle.
REQ-052 The bench SHALL cover: reset asserted mid-DUMP at word 300 -> dout_valid = 0 asynchronously; after release ld_ready = 1 and the next load writes img[0].

Source files
------------

// File: rtl/conv_mem_host_if.sv
// conv_mem_host_if: bundles the image-load, engine, layer-memory and dump signals of conv_mem_host.
// Ports (signals): load (ld_valid/ld_ready/ld_data), engine (ready/busy/iaddr/idata),
// layer memory (cwr/caddr_wr/cdata_wr/crd/caddr_rd/cdata_rd/csel),
// dump (dout_valid/dout_ready/dout_data/dout_last/done), sticky err.
// master = environment side, slave = conv_mem_host side.
interface conv_mem_host_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [12:0] ld_data;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [12:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [12:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [12:0] cdata_rd;
  logic        csel;
  logic        dout_valid;
  logic        dout_ready;
  logic [12:0] dout_data;
  logic        dout_last;
  logic        done;
  logic        err;
  modport master (
    output ld_valid, ld_data, busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, dout_ready,
    input  ld_ready, ready, idata, cdata_rd, dout_valid, dout_data, dout_last, done, err
  );
  modport slave (
    input  ld_valid, ld_data, busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, dout_ready,
    output ld_ready, ready, idata, cdata_rd, dout_valid, dout_data, dout_last, done, err
  );
endinterface

// File: rtl/conv_mem_host.sv
// conv_mem_host: image/layer memory host for a convolution engine (load -> start -> run -> dump -> done).
// Ports: clk, reset (async, active-high), bus (conv_mem_host_if.slave).
module conv_mem_host (
  input logic             clk,
  input logic             reset,
  conv_mem_host_if.slave  bus
);
  typedef enum logic [2:0] {LOAD, START, RUN, DUMP, DONE} state_t;
  state_t      r_state, w_next;
  logic [11:0] r_ld_cnt;
  logic [9:0]  r_d_cnt;
  logic        r_ready, r_err;
  logic [12:0] r_img [4096];
  logic [12:0] r_l0  [4096];
  logic [12:0] r_l1  [1024];
  logic        w_ld_acc, w_run_wr, w_wr0, w_wr1, w_wr_err, w_rd_err, w_d_acc;
  assign w_ld_acc = bus.ld_valid & bus.ld_ready;
  assign w_run_wr = (r_state == RUN) & bus.cwr;
  assign w_wr0    = w_run_wr & ~bus.csel;
  assign w_wr1    = w_run_wr & bus.csel & (bus.caddr_wr[11:10] == 2'd0);
  assign w_wr_err = w_run_wr & bus.csel & (|bus.caddr_wr[11:10]);
  assign w_rd_err = bus.crd & bus.csel & (|bus.caddr_rd[11:10]);
  assign w_d_acc  = bus.dout_valid & bus.dout_ready;
  assign bus.ld_ready   = r_state == LOAD;
  assign bus.ready      = r_ready;
  assign bus.idata      = r_img[bus.iaddr];
  // Reads see the array before this edge's write, giving read-before-write on a collision.
  assign bus.cdata_rd   = !bus.crd ? 13'd0 :
                          !bus.csel ? r_l0[bus.caddr_rd] :
                          w_rd_err ? 13'd0 : r_l1[bus.caddr_rd[9:0]];
  assign bus.dout_valid = r_state == DUMP;
  assign bus.dout_data  = bus.dout_valid ? r_l1[r_d_cnt] : 13'd0;
  assign bus.dout_last  = bus.dout_valid & (&r_d_cnt);
  assign bus.done       = r_state == DONE;
  assign bus.err        = r_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    w_next = (w_ld_acc && &r_ld_cnt) ? START : LOAD;
      START:   w_next = bus.busy ? RUN : START;
      RUN:     w_next = bus.busy ? RUN : DUMP;
      DUMP:    w_next = (w_d_acc && &r_d_cnt) ? DONE : DUMP;
      DONE:    w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end
  // Counters wrap to zero on their final increment, which is exactly the clear on leaving LOAD/DUMP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= LOAD;
      r_ld_cnt <= '0;
      r_d_cnt  <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next == START;
      if (w_ld_acc) r_ld_cnt <= r_ld_cnt + 12'd1;
      if (w_d_acc) r_d_cnt <= r_d_cnt + 10'd1;
      if (w_wr_err | w_rd_err) r_err <= 1'b1;
    end
  end
  // Memories are deliberately outside the reset domain so their contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ld_acc) r_img[r_ld_cnt] <= bus.ld_data;
    if (w_wr0) r_l0[bus.caddr_wr] <= bus.cdata_wr;
    if (w_wr1) r_l1[bus.caddr_wr[9:0]] <= bus.cdata_wr;
  end
endmodule

// File: tb/tb_conv_mem_host.sv
// tb_conv_mem_host: directed self-checking bench for conv_mem_host.
module tb_conv_mem_host;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  conv_mem_host_if bus ();
  conv_mem_host dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_all(input bit gaps);
    int acc = 0;
    int cyc = 0;
    int nrdy = 0;
    while (acc < 4096 && cyc < 20000) begin
      bus.ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.ld_data  = 13'(acc);
      #1;
      if (!bus.ld_ready) nrdy++;
      if (bus.ld_valid && bus.ld_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.ld_valid = 1'b0;
    chk("load_accepted", acc, 4096);
    chk("load_ready_drops", nrdy, 0);
  endtask
  initial begin
    int idx;
    bit ph;
    int cyc;
    bus.ld_valid = 0; bus.ld_data = 0; bus.busy = 0; bus.iaddr = 0;
    bus.cwr = 0; bus.caddr_wr = 0; bus.cdata_wr = 0; bus.crd = 0;
    bus.caddr_rd = 0; bus.csel = 0; bus.dout_ready = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_ld_ready", bus.ld_ready, 1);
    chk("rst_ready", bus.ready, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout_last", bus.dout_last, 0);
    chk("rst_dout_data", bus.dout_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    tick();
    reset = 1'b0;
    tick();
    // session 1: gapped load
    load_all(1);
    #1;
    chk("ready_after_load", bus.ready, 1);
    chk("ld_ready_after_load", bus.ld_ready, 0);
    bus.iaddr = 12'h041;
    #1;
    chk("img_041", bus.idata, 13'h041);
    bus.iaddr = 12'hFFF;
    #1;
    chk("img_fff", bus.idata, 13'hFFF);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 13'h1FFF;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("start_hold_ready", bus.ready, 1);
    end
    bus.ld_valid = 1'b0;
    bus.busy = 1'b1;
    tick();
    chk("ready_clear_on_busy", bus.ready, 0);
    bus.iaddr = 12'h000;
    #1;
    chk("img0_not_written_outside_load", bus.idata, 0);
    // RUN: layer0 read-before-write
    bus.cwr = 1; bus.csel = 0; bus.caddr_wr = 12'h7FF; bus.cdata_wr = 13'h0AAA;
    tick();
    bus.cdata_wr = 13'h0123; bus.crd = 1; bus.caddr_rd = 12'h7FF;
    #1;
    chk("l0_rbw_old", bus.cdata_rd, 13'h0AAA);
    tick();
    bus.cwr = 0;
    #1;
    chk("l0_rbw_new", bus.cdata_rd, 13'h0123);
    bus.crd = 0;
    bus.cwr = 1; bus.caddr_wr = 12'h010; bus.cdata_wr = 13'h0222;
    tick();
    // fill layer1[i] = i
    bus.csel = 1;
    for (int i = 0; i < 1024; i++) begin
      bus.caddr_wr = 12'(i);
      bus.cdata_wr = 13'(i);
      tick();
    end
    bus.cwr = 0;
    chk("err_clean_fill", bus.err, 0);
    bus.crd = 1; bus.caddr_rd = 12'h3FF;
    #1;
    chk("l1_3ff", bus.cdata_rd, 13'h3FF);
    bus.crd = 0;
    bus.cwr = 1; bus.caddr_wr = 12'h400; bus.cdata_wr = 13'h0055;
    tick();
    bus.cwr = 0;
    chk("err_l1_wr_oob", bus.err, 1);
    bus.crd = 1; bus.caddr_rd = 12'h000;
    #1;
    chk("l1_0_unchanged", bus.cdata_rd, 0);
    bus.caddr_rd = 12'h800;
    #1;
    chk("l1_rd_oob_zero", bus.cdata_rd, 0);
    bus.crd = 0;
    chk("dout_data_zero_run", bus.dout_data, 0);
    // DUMP
    bus.busy = 0;
    tick();
    bus.cwr = 1; bus.csel = 0; bus.caddr_wr = 12'h010; bus.cdata_wr = 13'h1111;
    #1;
    chk("dump_first_valid", bus.dout_valid, 1);
    chk("dump_first_data", bus.dout_data, 0);
    tick();
    bus.cwr = 0; bus.crd = 1; bus.caddr_rd = 12'h010;
    #1;
    chk("cwr_ignored_outside_run", bus.cdata_rd, 13'h0222);
    chk("dump_stall_data", bus.dout_data, 0);
    bus.crd = 0;
    tick();
    idx = 0; ph = 0; cyc = 0;
    while (idx < 1024 && cyc < 4000) begin
      bus.dout_ready = ph;
      #1;
      chk("dump_valid", bus.dout_valid, 1);
      chk("dump_data", bus.dout_data, 32'(idx));
      chk("dump_last", bus.dout_last, 32'(idx == 1023));
      if (ph) idx++;
      ph = ~ph;
      tick();
      cyc++;
    end
    bus.dout_ready = 0;
    chk("dump_count", idx, 1024);
    #1;
    chk("done_pulse", bus.done, 1);
    chk("done_dout_valid", bus.dout_valid, 0);
    chk("done_dout_data", bus.dout_data, 0);
    chk("done_err_held", bus.err, 1);
    tick();
    #1;
    chk("done_one_cycle", bus.done, 0);
    chk("ld_ready_after_done", bus.ld_ready, 1);
    // session 2: busy high during LOAD is ignored
    bus.busy = 1;
    tick();
    load_all(0);
    #1;
    chk("s2_ready", bus.ready, 1);
    tick();
    chk("s2_ready_clear", bus.ready, 0);
    bus.busy = 0;
    tick();
    bus.dout_ready = 1;
    repeat (300) @(posedge clk);
    #1;
    chk("s2_word300", bus.dout_data, 300);
    bus.dout_ready = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_dout_valid", bus.dout_valid, 0);
    chk("async_rst_dout_data", bus.dout_data, 0);
    chk("async_rst_ld_ready", bus.ld_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ld_ready", bus.ld_ready, 1);
    chk("post_rst_ready", bus.ready, 0);
    chk("post_rst_err", bus.err, 0);
    chk("post_rst_dout_last", bus.dout_last, 0);
    bus.ld_valid = 1; bus.ld_data = 13'h0BAD;
    tick();
    bus.ld_valid = 0;
    bus.iaddr = 12'h000;
    #1;
    chk("reload_img0", bus.idata, 13'h0BAD);
    bus.iaddr = 12'h001;
    #1;
    chk("reload_img1_kept", bus.idata, 1);
    bus.crd = 1; bus.csel = 1; bus.caddr_rd = 12'h800;
    #1;
    chk("l1_rd_oob_load", bus.cdata_rd, 0);
    tick();
    chk("err_l1_rd_oob", bus.err, 1);
    bus.caddr_rd = 12'h005;
    #1;
    chk("l1_kept_over_reset", bus.cdata_rd, 5);
    bus.crd = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
